// File: rtl/bus_mem_target_if.sv
// Bus bundle for the ce/rd/wr CPU bus between a master and a memory target.
interface bus_mem_target_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) ();
    logic            ce;
    logic            rd;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data_wr;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data_rd;
    logic            ready;
    logic            err;

    modport master (
        output ce, rd, wr, addr, data_wr, be,
        input  data_rd, ready, err
    );

    modport slave (
        input  ce, rd, wr, addr, data_wr, be,
        output data_rd, ready, err
    );
endinterface

// File: rtl/bus_mem_target.sv
// On-chip scratch RAM target for the ce/rd/wr CPU bus: byte-enabled writes,
// programmable wait states, one-cycle ready pulse with error flag.
module bus_mem_target #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst,
    bus_mem_target_if.slave bus
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      wait_cnt;
    logic [AW-1:0]   cap_addr;
    logic [DW-1:0]   cap_wdata;
    logic [BW-1:0]   cap_be;
    logic            cap_rd;
    logic            cap_wr;
    logic            request;
    logic            cap_oob;
    logic            cap_bad;
    logic            commit;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   data_rd_q;
    logic            err_q;
    logic [DW-1:0]   mem [DEPTH];

    assign request = bus.ce & (bus.rd | bus.wr);
    assign cap_oob = (32'(cap_addr) >= DEPTH);
    assign cap_bad = (cap_rd & cap_wr) | cap_oob;
    assign idx     = cap_addr[IW-1:0];
    // The edge leaving WAIT with an expired counter is the edge that enters RESP.
    assign commit  = (state == WAIT) && (wait_cnt == 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. Every access passes through WAIT with the counter
    // loaded to WAIT_STATES, so RESP follows capture by WAIT_STATES+1 edges.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (request) state_nxt = WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and wait-state countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE && request) begin
            cap_addr  <= bus.addr;
            cap_wdata <= bus.data_wr;
            cap_be    <= bus.be;
            cap_rd    <= bus.rd;
            cap_wr    <= bus.wr;
            wait_cnt  <= 4'(WAIT_STATES);
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Read data and error status, updated on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rd_q <= '0;
            err_q     <= 1'b0;
        end else if (commit) begin
            err_q <= cap_bad;
            if (cap_rd && !cap_wr) begin
                if (cap_oob) data_rd_q <= '0;
                else         data_rd_q <= mem[idx];
            end
        end
    end

    // Byte-enabled memory write; contents are never reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && cap_wr && !cap_bad) begin
            for (int unsigned i = 0; i < BW; i++) begin
                if (cap_be[i]) mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ready   = (state == RESP);
    assign bus.err     = (state == RESP) & err_q;
    assign bus.data_rd = data_rd_q;
endmodule

// File: tb/tb_bus_mem_target.sv
// Randomized self-checking bench for bus_mem_target: an 8-bit default
// instance and a 16-bit, 200-word, 3-wait-state instance share one driver.
module tb_bus_mem_target;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        ce, rd, wr;
    logic [7:0]  addr;
    logic [15:0] data_wr;
    logic [1:0]  be;
    logic [15:0] obs_rd;
    logic        obs_ready, obs_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [2][256];
    logic [15:0] m_rd  [2];

    always #5 clk = ~clk;

    bus_mem_target_if #(.AW(8), .DW(8))  bus_a ();
    bus_mem_target_if #(.AW(8), .DW(16)) bus_b ();

    assign bus_a.ce      = ce & ~sel;
    assign bus_a.rd      = rd;
    assign bus_a.wr      = wr;
    assign bus_a.addr    = addr;
    assign bus_a.data_wr = data_wr[7:0];
    assign bus_a.be      = be[0:0];

    assign bus_b.ce      = ce & sel;
    assign bus_b.rd      = rd;
    assign bus_b.wr      = wr;
    assign bus_b.addr    = addr;
    assign bus_b.data_wr = data_wr;
    assign bus_b.be      = be;

    bus_mem_target #(.AW(8), .DW(8), .DEPTH(256), .WAIT_STATES(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bus_mem_target #(.AW(8), .DW(16), .DEPTH(200), .WAIT_STATES(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always_comb begin
        if (sel) begin
            obs_rd    = bus_b.data_rd;
            obs_ready = bus_b.ready;
            obs_err   = bus_b.err;
        end else begin
            obs_rd    = {8'h00, bus_a.data_rd};
            obs_ready = bus_a.ready;
            obs_err   = bus_a.err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned depth_of(input logic s);
        return s ? 200 : 256;
    endfunction

    function automatic int unsigned ws_of(input logic s);
        return s ? 3 : 0;
    endfunction

    function automatic logic [1:0] bmask_of(input logic s);
        return s ? 2'b11 : 2'b01;
    endfunction

    // One bus access from request to ready; the model is updated from the bus rules.
    task automatic access(input logic s, input logic r, input logic w, input logic [7:0] a,
                          input logic [15:0] d, input logic [1:0] b, input string tag);
        int          n;
        logic        oob, bad;
        logic [1:0]  bm;
        @(negedge clk);
        sel = s; ce = 1'b1; rd = r; wr = w; addr = a; data_wr = d; be = b;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!obs_ready && n < 40);
        oob = (32'(a) >= depth_of(s));
        bad = (r && w) || oob;
        bm  = b & bmask_of(s);
        if (!bad && w) begin
            for (int i = 0; i < 2; i++)
                if (bm[i]) m_mem[s][a][8*i +: 8] = d[8*i +: 8];
        end
        if (r && !w) m_rd[s] = oob ? 16'h0000 : m_mem[s][a];
        check({tag, "_latency"}, 32'(n), 32'(ws_of(s) + 2));
        check({tag, "_err"}, 32'(obs_err), 32'(bad));
        check({tag, "_data_rd"}, 32'(obs_rd), 32'(m_rd[s]));
        @(negedge clk);
        ce = 1'b0; rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_pulse"}, 32'(obs_ready), 32'd0);
    endtask

    // Starts a write and applies reset after k edges (capture edge included).
    task automatic abort_write(input logic s, input logic [7:0] a, input logic [15:0] d,
                               input int k, input string tag);
        int seen;
        seen = 0;
        @(negedge clk);
        sel = s; ce = 1'b1; rd = 1'b0; wr = 1'b1; addr = a; data_wr = d; be = 2'b11;
        repeat (k) begin
            @(posedge clk); #1;
            if (obs_ready) seen++;
        end
        @(negedge clk);
        rst = 1'b1; ce = 1'b0; wr = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (obs_ready) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (obs_ready) seen++;
        end
        m_rd[0] = 16'h0000;
        m_rd[1] = 16'h0000;
        check({tag, "_no_ready"}, 32'(seen), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            check({tag, i[0] ? "_b_ready" : "_a_ready"}, 32'(obs_ready), 32'd0);
            check({tag, i[0] ? "_b_err" : "_a_err"}, 32'(obs_err), 32'd0);
            check({tag, i[0] ? "_b_data_rd" : "_a_data_rd"}, 32'(obs_rd), 32'(m_rd[i]));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  ra;
        logic [15:0] rdat;
        logic [1:0]  rbe;
        int unsigned op;
        logic        rs;

        rst = 1'b1; sel = 1'b0; ce = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; data_wr = '0; be = '0;
        for (int s = 0; s < 2; s++) begin
            m_rd[s] = 16'h0000;
            for (int a = 0; a < 256; a++) m_mem[s][a] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Preload both memories with known random contents.
        for (int a = 0; a < 256; a++) begin
            access(1'b0, 1'b0, 1'b1, 8'(a), 16'($urandom), 2'b11, "preload_a");
            if (a < 200) access(1'b1, 1'b0, 1'b1, 8'(a), 16'($urandom), 2'b11, "preload_b");
        end

        // Default instance: write then read back.
        access(1'b0, 1'b0, 1'b1, 8'h11, 16'h00AA, 2'b01, "t1_wr");
        access(1'b0, 1'b1, 1'b0, 8'h11, 16'h0000, 2'b00, "t1_rd");
        check("t1_value", 32'(obs_rd), 32'h00AA);

        // Three wait states on a preloaded address.
        access(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 2'b00, "t2_rd");

        // Partial byte-enable merge on the 16-bit instance.
        access(1'b1, 1'b0, 1'b1, 8'h05, 16'h1234, 2'b11, "t3_wr_full");
        access(1'b1, 1'b0, 1'b1, 8'h05, 16'hABCD, 2'b01, "t3_wr_low");
        access(1'b1, 1'b0, 1'b1, 8'h05, 16'hFFFF, 2'b00, "t3_wr_none");
        access(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b00, "t3_rd");
        check("t3_value", 32'(obs_rd), 32'h12CD);

        // rd and wr together: error, no write, data_rd unchanged.
        access(1'b0, 1'b0, 1'b1, 8'h20, 16'h0055, 2'b01, "t4_wr");
        access(1'b0, 1'b1, 1'b0, 8'h11, 16'h0000, 2'b00, "t4_rd_other");
        access(1'b0, 1'b1, 1'b1, 8'h20, 16'h0099, 2'b01, "t4_both");
        check("t4_data_kept", 32'(obs_rd), 32'h00AA);
        access(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 2'b00, "t4_rd");
        check("t4_value", 32'(obs_rd), 32'h0055);

        // Out-of-range on the 200-word instance, plus the last valid word.
        access(1'b1, 1'b0, 1'b1, 8'hF0, 16'h0077, 2'b11, "t5_wr_oob");
        access(1'b1, 1'b0, 1'b1, 8'd199, 16'hBEEF, 2'b11, "t5_wr_last");
        access(1'b1, 1'b1, 1'b0, 8'd199, 16'h0000, 2'b00, "t5_rd_last");
        access(1'b1, 1'b1, 1'b0, 8'd200, 16'h0000, 2'b00, "t5_rd_first_oob");
        access(1'b1, 1'b1, 1'b0, 8'hF0, 16'h0000, 2'b00, "t5_rd_oob");
        check("t5_value", 32'(obs_rd), 32'h0000);

        // Reset during WAIT abandons the write.
        access(1'b1, 1'b0, 1'b1, 8'h3C, 16'h0000, 2'b11, "t6_clear");
        abort_write(1'b1, 8'h3C, 16'h0099, 2, "t6_abort");
        check_idle_outputs("t6_after_reset");
        access(1'b1, 1'b1, 1'b0, 8'h3C, 16'h0000, 2'b00, "t6_rd");
        check("t6_value", 32'(obs_rd), 32'h0000);

        // Reset on the edge that would enter RESP also abandons the write.
        abort_write(1'b0, 8'h40, 16'h005A, 1, "t7_abort");
        access(1'b0, 1'b1, 1'b0, 8'h40, 16'h0000, 2'b00, "t7_rd");

        // Randomized mix of reads, writes and illegal accesses on both instances.
        for (int i = 0; i < 300; i++) begin
            rs   = 1'($urandom_range(0, 1));
            ra   = 8'($urandom);
            rdat = 16'($urandom);
            rbe  = 2'($urandom);
            op   = $urandom_range(0, 9);
            if (op == 0)     access(rs, 1'b1, 1'b1, ra, rdat, rbe, "rand_both");
            else if (op < 5) access(rs, 1'b1, 1'b0, ra, rdat, rbe, "rand_rd");
            else             access(rs, 1'b0, 1'b1, ra, rdat, rbe, "rand_wr");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
